// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO between a bursty host write port and the UART serializer.
// Pointers carry an extra wrap bit so full/empty/level come straight from registered state.
module uart_tx_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overflow,
   input  logic                       clr_ovf,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   // Full is judged before any same-cycle pop, so a write into a full FIFO is always dropped.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                        (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign level       = wr_ptr - rd_ptr;
   assign almost_full = (level >= AF_THRESH);
   assign tx_valid    = !empty;
   assign tx_data     = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

   assign push = wr_en && !full;
   assign pop  = tx_valid && tx_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && full) overflow <= 1'b1;
         else if (clr_ovf)  overflow <= 1'b0;
      end
   end

   // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule
